// File: rtl/mem_client_pkg.sv
// Shared definitions for the DDR client port: FSM encoding, timing defaults
// and the row/bank/column split of a controller address.
package mem_client_pkg;

    localparam int MCP_ADDR_W     = 27;
    localparam int MCP_DATA_W     = 32;
    localparam int MCP_LEN_W      = 4;
    // Two x16 columns make one 32-bit word, so a beat advances the column by 2.
    localparam int MCP_ADDR_STEP  = 2;
    // Edges from the latch edge to the edge that samples DATA_R.
    localparam int MCP_RD_LATENCY = 3;

    // Address field split, kept identical to enter_state.
    localparam int ROW_MSB  = 26;
    localparam int ROW_LSB  = 15;
    localparam int BANK_MSB = 14;
    localparam int BANK_LSB = 13;
    localparam int COL_MSB  = 12;
    localparam int COL_LSB  = 0;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_WD,
        ISSUE,
        HOLD,
        DRAIN
    } state_t;

    typedef struct packed {
        logic [ROW_MSB-ROW_LSB:0]   row;
        logic [BANK_MSB-BANK_LSB:0] bank;
        logic [COL_MSB-COL_LSB:0]   col;
    } addr_split_t;

    function automatic addr_split_t split_addr(input logic [MCP_ADDR_W-1:0] a);
        addr_split_t s;
        s.row  = a[ROW_MSB:ROW_LSB];
        s.bank = a[BANK_MSB:BANK_LSB];
        s.col  = a[COL_MSB:COL_LSB];
        return s;
    endfunction

endpackage

// File: rtl/mem_client_port_if.sv
// User request / write data / read return plus the controller command
// handshake of the DDR client port. The port itself uses the slave view.
interface mem_client_port_if #(
    parameter int ADDR_W = 27,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
);
    // user request
    logic              REQ_VALID;
    logic              REQ_READY;
    logic [ADDR_W-1:0] REQ_ADDR;
    logic              REQ_WE;
    logic [LEN_W-1:0]  REQ_LEN;
    // user write data
    logic              WD_VALID;
    logic              WD_READY;
    logic [DATA_W-1:0] WD_DATA;
    // user read return and completion
    logic              RD_VALID;
    logic [DATA_W-1:0] RD_DATA;
    logic              DONE;
    // controller side
    logic [ADDR_W-1:0] ADDRESS_REQ;
    logic              WE;
    logic [DATA_W-1:0] DATA_W_OUT;
    logic              DO_ACT;
    logic              COMMAND_LATCHED;
    logic [DATA_W-1:0] DATA_R;

    modport slave (
        input  REQ_VALID, REQ_ADDR, REQ_WE, REQ_LEN, WD_VALID, WD_DATA,
               COMMAND_LATCHED, DATA_R,
        output REQ_READY, WD_READY, RD_VALID, RD_DATA, DONE,
               ADDRESS_REQ, WE, DATA_W_OUT, DO_ACT
    );

    modport master (
        output REQ_VALID, REQ_ADDR, REQ_WE, REQ_LEN, WD_VALID, WD_DATA,
               COMMAND_LATCHED, DATA_R,
        input  REQ_READY, WD_READY, RD_VALID, RD_DATA, DONE,
               ADDRESS_REQ, WE, DATA_W_OUT, DO_ACT
    );

endinterface

// File: rtl/mem_client_port_rd_latency_pipe.sv
// Fixed-latency read return tracker. Each read latch injects a token; the
// token walks RD_LATENCY stages and, on leaving the last one, DATA_R is
// captured and presented for one cycle. Tokens stay in issue order.
module rd_latency_pipe #(
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              inject,
    input  logic [DATA_W-1:0] data_r,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty
);

    logic [RD_LATENCY-1:0] vld_pipe;

    assign empty = ~|vld_pipe;

    // Shift tokens forward; capture controller data when a token falls out.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            vld_pipe <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            vld_pipe[0] <= inject;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
            end
            rd_valid <= vld_pipe[RD_LATENCY-1];
            if (vld_pipe[RD_LATENCY-1]) begin
                rd_data <= data_r;
            end
        end
    end

endmodule

// File: rtl/mem_client_port.sv
// Initiator side of the DDR controller client handshake. A user burst is
// issued one beat at a time: present (DO_ACT) until COMMAND_LATCHED, then
// one HOLD cycle with the command fields frozen so the controller can sample
// write data after the latch, then step the address. Reads return through a
// fixed-latency pipe; DONE marks the last write latch or the last read beat.
module mem_client_port
    import mem_client_pkg::*;
#(
    parameter int ADDR_W     = MCP_ADDR_W,
    parameter int DATA_W     = MCP_DATA_W,
    parameter int LEN_W      = MCP_LEN_W,
    parameter int ADDR_STEP  = MCP_ADDR_STEP,
    parameter int RD_LATENCY = MCP_RD_LATENCY
) (
    input  logic             CLK,
    input  logic             RST,
    mem_client_port_if.slave bus
);

    state_t            state_q;
    state_t            state_d;

    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [DATA_W-1:0] wdata_q;

    logic              req_ready;
    logic              wd_ready;
    logic              do_act;
    logic              done;
    logic              inject;
    logic              step;
    logic              accept;
    logic              wd_take;
    logic              last;

    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              pipe_empty;

    assign last    = (cnt_q == '0);
    assign accept  = req_ready & bus.REQ_VALID;
    assign wd_take = wd_ready & bus.WD_VALID;

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus handshake strobes. A latch only counts while the beat
    // is presented, so COMMAND_LATCHED in any other state is ignored.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        wd_ready  = 1'b0;
        do_act    = 1'b0;
        done      = 1'b0;
        inject    = 1'b0;
        step      = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.REQ_VALID) begin
                    state_d = bus.REQ_WE ? WAIT_WD : ISSUE;
                end
            end
            WAIT_WD: begin
                wd_ready = 1'b1;
                if (bus.WD_VALID) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                do_act = 1'b1;
                if (bus.COMMAND_LATCHED) begin
                    inject  = ~we_q;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                step = 1'b1;
                if (!last) begin
                    state_d = we_q ? WAIT_WD : ISSUE;
                end else if (we_q) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // The last token has left the pipe exactly when its beat is
                // being returned, so completion coincides with that RD_VALID.
                if (pipe_empty && rd_valid) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Burst context: address/direction/count on accept, write data on the
    // data handshake, address step and count-down when leaving HOLD.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
            wdata_q <= '0;
        end else begin
            if (accept) begin
                addr_q <= bus.REQ_ADDR;
                we_q   <= bus.REQ_WE;
                cnt_q  <= bus.REQ_LEN;
            end
            if (wd_take) begin
                wdata_q <= bus.WD_DATA;
            end
            if (step) begin
                addr_q <= addr_q + ADDR_W'(ADDR_STEP);
                if (!last) begin
                    cnt_q <= cnt_q - LEN_W'(1);
                end
            end
        end
    end

    rd_latency_pipe #(
        .DATA_W     (DATA_W),
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_pipe (
        .CLK      (CLK),
        .RST      (RST),
        .inject   (inject),
        .data_r   (bus.DATA_R),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .empty    (pipe_empty)
    );

    assign bus.REQ_READY   = req_ready;
    assign bus.WD_READY    = wd_ready;
    assign bus.DO_ACT      = do_act;
    assign bus.DONE        = done;
    assign bus.ADDRESS_REQ = addr_q;
    assign bus.WE          = we_q;
    assign bus.DATA_W_OUT  = wdata_q;
    assign bus.RD_VALID    = rd_valid;
    assign bus.RD_DATA     = rd_data;

endmodule

// File: tb/tb_mem_client_port.sv
// Bench for mem_client_port: the bench plays both the user and the
// controller, randomizing latch delays, write-data delays and stray inputs,
// and predicts every output from the protocol rules of the port.
module tb_mem_client_port;

    localparam int AW  = 27;
    localparam int DW  = 32;
    localparam int LW  = 4;
    localparam int LAT = 3;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    logic [DW-1:0] rtab [256];

    typedef struct {
        int            c;
        logic [DW-1:0] d;
    } rexp_t;
    rexp_t rq[$];

    mem_client_port_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus();

    mem_client_port #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .LEN_W      (LW),
        .ADDR_STEP  (2),
        .RD_LATENCY (LAT)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Controller read data: a random word per cycle, so the captured beat
    // identifies exactly which edge sampled it.
    assign bus.DATA_R = rtab[cyc % 256];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr_inputs();
        bus.REQ_VALID       = 1'b0;
        bus.REQ_ADDR        = '0;
        bus.REQ_WE          = 1'b0;
        bus.REQ_LEN         = '0;
        bus.WD_VALID        = 1'b0;
        bus.WD_DATA         = '0;
        bus.COMMAND_LATCHED = 1'b0;
    endtask

    task automatic test_reset();
        clr_inputs();
        RST = 1'b0;
        repeat (2) tick();
        n_chk++;
        if ({bus.REQ_READY, bus.WD_READY, bus.DO_ACT, bus.RD_VALID, bus.DONE, bus.WE} !== 6'b100000)
            $display("FAIL reset_ctl got=%b exp=100000",
                     {bus.REQ_READY, bus.WD_READY, bus.DO_ACT, bus.RD_VALID, bus.DONE, bus.WE});
        else n_pass++;
        n_chk++;
        if (bus.ADDRESS_REQ !== '0) $display("FAIL reset_addr got=%h exp=0", bus.ADDRESS_REQ);
        else n_pass++;
        n_chk++;
        if (bus.DATA_W_OUT !== '0) $display("FAIL reset_wdata got=%h exp=0", bus.DATA_W_OUT);
        else n_pass++;
        @(negedge CLK);
        RST = 1'b1;
        tick();
        n_chk++;
        if (bus.REQ_READY !== 1'b1 || bus.DO_ACT !== 1'b0)
            $display("FAIL reset_release got=%b%b exp=10", bus.REQ_READY, bus.DO_ACT);
        else n_pass++;
    endtask

    // One burst: request, then per cycle compare the port against the
    // expected protocol phase and drive the controller/user side.
    // lat / wd_dly < 0 pick random delays per beat.
    task automatic test_burst(input string nm, input bit we, input logic [AW-1:0] base,
                              input int len, input int lat, input int wd_dly,
                              input bit stray, input logic [DW-1:0] wd_base);
        int            nb;
        int            b;
        int            lat_w;
        int            wd_w;
        int            n_rd;
        int            n_latch;
        int            guard;
        bit            pres, want, hold, n_pres, n_want, n_hold;
        bit            done_seen, exp_rv, exp_done;
        logic [AW-1:0] ea;
        logic [DW-1:0] wd [16];
        nb = len + 1;
        b = 0; n_rd = 0; n_latch = 0; guard = 0; done_seen = 1'b0;
        for (int i = 0; i < 16; i++) wd[i] = (wd_base != '0) ? wd_base + DW'(i) : DW'($urandom);
        rq.delete();

        n_chk++;
        if (bus.REQ_READY !== 1'b1) $display("FAIL %s idle_ready got=%b exp=1", nm, bus.REQ_READY);
        else n_pass++;
        bus.REQ_VALID = 1'b1;
        bus.REQ_ADDR  = base;
        bus.REQ_WE    = we;
        bus.REQ_LEN   = LW'(len);
        tick();
        pres  = !we;
        want  = we;
        hold  = 1'b0;
        lat_w = (lat < 0) ? int'($urandom_range(3, 0)) : lat;
        wd_w  = (wd_dly < 0) ? int'($urandom_range(3, 0)) : wd_dly;

        while (!done_seen && guard < 400) begin
            guard++;
            exp_rv   = (rq.size() != 0) && (rq[0].c == cyc);
            exp_done = we ? (hold && b == nb) : (exp_rv && b == nb && rq.size() == 1);

            n_chk++;
            if (bus.DO_ACT !== pres) $display("FAIL %s do_act cyc=%0d got=%b exp=%b", nm, cyc, bus.DO_ACT, pres);
            else n_pass++;
            n_chk++;
            if (bus.WD_READY !== want) $display("FAIL %s wd_ready cyc=%0d got=%b exp=%b", nm, cyc, bus.WD_READY, want);
            else n_pass++;
            n_chk++;
            if (bus.REQ_READY !== 1'b0) $display("FAIL %s busy_ready cyc=%0d got=%b exp=0", nm, cyc, bus.REQ_READY);
            else n_pass++;
            n_chk++;
            if (bus.RD_VALID !== exp_rv) $display("FAIL %s rd_valid cyc=%0d got=%b exp=%b", nm, cyc, bus.RD_VALID, exp_rv);
            else n_pass++;
            n_chk++;
            if (bus.DONE !== exp_done) $display("FAIL %s done cyc=%0d got=%b exp=%b", nm, cyc, bus.DONE, exp_done);
            else n_pass++;
            if (pres) begin
                ea = base + AW'(2 * b);
                n_chk++;
                if (bus.ADDRESS_REQ !== ea || bus.WE !== we || (we && bus.DATA_W_OUT !== wd[b]))
                    $display("FAIL %s issue beat=%0d got=%h/%b/%h exp=%h/%b/%h", nm, b,
                             bus.ADDRESS_REQ, bus.WE, bus.DATA_W_OUT, ea, we, wd[b]);
                else n_pass++;
            end
            if (hold) begin
                ea = base + AW'(2 * (b - 1));
                n_chk++;
                if (bus.ADDRESS_REQ !== ea || bus.WE !== we || (we && bus.DATA_W_OUT !== wd[b-1]))
                    $display("FAIL %s hold beat=%0d got=%h/%b/%h exp=%h/%b/%h", nm, b - 1,
                             bus.ADDRESS_REQ, bus.WE, bus.DATA_W_OUT, ea, we, wd[b-1]);
                else n_pass++;
            end
            if (exp_rv) begin
                n_chk++;
                if (bus.RD_DATA !== rq[0].d)
                    $display("FAIL %s rd_data beat=%0d got=%h exp=%h", nm, n_rd, bus.RD_DATA, rq[0].d);
                else n_pass++;
                void'(rq.pop_front());
                n_rd++;
            end
            if (exp_done) done_seen = 1'b1;

            // drive this cycle's inputs; stray ones must have no effect
            bus.REQ_VALID       = stray && ($urandom_range(1, 0) == 1);
            bus.REQ_ADDR        = AW'($urandom);
            bus.REQ_WE          = ($urandom_range(1, 0) == 1);
            bus.REQ_LEN         = LW'($urandom);
            bus.COMMAND_LATCHED = stray && !pres && ($urandom_range(1, 0) == 1);
            bus.WD_VALID        = stray && !want && ($urandom_range(1, 0) == 1);
            bus.WD_DATA         = DW'($urandom);
            n_pres = pres; n_want = want; n_hold = 1'b0;
            if (want) begin
                if (wd_w == 0) begin
                    bus.WD_VALID = 1'b1;
                    bus.WD_DATA  = wd[b];
                    n_want = 1'b0;
                    n_pres = 1'b1;
                end else wd_w--;
            end
            if (pres) begin
                if (lat_w == 0) begin
                    bus.COMMAND_LATCHED = 1'b1;
                    if (!we) rq.push_back('{c: cyc + 1 + LAT, d: rtab[(cyc + LAT) % 256]});
                    b++;
                    n_latch++;
                    n_pres = 1'b0;
                    n_hold = 1'b1;
                    lat_w = (lat < 0) ? int'($urandom_range(3, 0)) : lat;
                end else lat_w--;
            end
            if (hold && b < nb) begin
                if (we) begin
                    n_want = 1'b1;
                    wd_w = (wd_dly < 0) ? int'($urandom_range(3, 0)) : wd_dly;
                end else n_pres = 1'b1;
            end
            pres = n_pres; want = n_want; hold = n_hold;
            tick();
        end
        clr_inputs();

        n_chk++;
        if (!done_seen) $display("FAIL %s timeout got=no_done exp=done within 400 cycles", nm);
        else n_pass++;
        n_chk++;
        if (n_latch != nb || (!we && n_rd != nb))
            $display("FAIL %s beats got=%0d latches/%0d reads exp=%0d", nm, n_latch, n_rd, nb);
        else n_pass++;
        n_chk++;
        if ({bus.REQ_READY, bus.DO_ACT, bus.RD_VALID, bus.DONE} !== 4'b1000)
            $display("FAIL %s after_done got=%b exp=1000", nm,
                     {bus.REQ_READY, bus.DO_ACT, bus.RD_VALID, bus.DONE});
        else n_pass++;
    endtask

    task automatic test_reset_mid_read();
        clr_inputs();
        bus.REQ_VALID = 1'b1;
        bus.REQ_ADDR  = 27'h0040000;
        bus.REQ_WE    = 1'b0;
        bus.REQ_LEN   = 4'd7;
        tick();
        clr_inputs();
        // latch beat 0, hold, latch beat 1; end in the second HOLD cycle
        for (int k = 0; k < 3; k++) begin
            if (k % 2 == 0) begin
                n_chk++;
                if (bus.DO_ACT !== 1'b1) $display("FAIL rst_mid do_act k=%0d got=%b exp=1", k, bus.DO_ACT);
                else n_pass++;
                bus.COMMAND_LATCHED = 1'b1;
            end else bus.COMMAND_LATCHED = 1'b0;
            tick();
        end
        bus.COMMAND_LATCHED = 1'b0;
        #2 RST = 1'b0;
        #1;
        n_chk++;
        if ({bus.REQ_READY, bus.WD_READY, bus.DO_ACT, bus.RD_VALID, bus.DONE, bus.WE} !== 6'b100000)
            $display("FAIL rst_mid ctl got=%b exp=100000",
                     {bus.REQ_READY, bus.WD_READY, bus.DO_ACT, bus.RD_VALID, bus.DONE, bus.WE});
        else n_pass++;
        n_chk++;
        if (bus.ADDRESS_REQ !== '0 || bus.DATA_W_OUT !== '0)
            $display("FAIL rst_mid fields got=%h/%h exp=0/0", bus.ADDRESS_REQ, bus.DATA_W_OUT);
        else n_pass++;
        @(negedge CLK);
        RST = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            n_chk++;
            if (bus.RD_VALID !== 1'b0 || bus.REQ_READY !== 1'b1 || bus.DO_ACT !== 1'b0)
                $display("FAIL rst_mid after k=%0d got=%b%b%b exp=010", k, bus.RD_VALID, bus.REQ_READY, bus.DO_ACT);
            else n_pass++;
        end
    endtask

    // Latch pulses while idle must not start anything or move the address.
    task automatic test_stray_idle();
        clr_inputs();
        for (int k = 0; k < 6; k++) begin
            bus.COMMAND_LATCHED = 1'b1;
            tick();
            n_chk++;
            if ({bus.REQ_READY, bus.DO_ACT, bus.WD_READY, bus.RD_VALID, bus.DONE} !== 5'b10000 || bus.ADDRESS_REQ !== '0)
                $display("FAIL stray_idle k=%0d got=%b/%h exp=10000/0", k,
                         {bus.REQ_READY, bus.DO_ACT, bus.WD_READY, bus.RD_VALID, bus.DONE}, bus.ADDRESS_REQ);
            else n_pass++;
        end
        clr_inputs();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rtab[i] = DW'($urandom);
        clr_inputs();
        test_reset();
        test_burst("single_read", 1'b0, 27'h0000100, 0, 2, 0, 1'b0, 32'h0);
        test_burst("write_wrap", 1'b1, 27'h7FFFFFE, 3, 1, 0, 1'b0, 32'hA0);
        test_burst("wd_stall", 1'b1, 27'h0000200, 1, 0, 5, 1'b1, 32'h0);
        test_burst("read16", 1'b0, 27'h0123400, 15, 0, 0, 1'b0, 32'h0);
        test_burst("stray_read", 1'b0, 27'h7FFFFF8, 5, -1, 0, 1'b1, 32'h0);
        test_reset_mid_read();
        test_stray_idle();
        for (int r = 0; r < 6; r++) begin
            test_burst("random", ($urandom_range(1, 0) == 1), AW'($urandom),
                       int'($urandom_range(15, 0)), -1, -1, ($urandom_range(1, 0) == 1), 32'h0);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=running exp=finished by 1ms");
        $fatal(1, "watchdog expired");
    end

endmodule
